// File: rtl/udp_audio_depacketizer_if.sv
// Interface bundling the UDP receive byte stream, DAC sample strobe and playback/status outputs.
// Optional macro UDP_AUDIO_SEQ_CHECK_EN adds the seq_gap_cnt status signal.
interface udp_audio_depacketizer_if #(
  parameter int unsigned FIFO_AW = 8,
  parameter int unsigned CNT_W   = 16
);
  logic                 udp_rec_data_valid;
  logic [7:0]           udp_rec_rdata;
  logic [15:0]          udp_rec_data_length;
  logic                 sample_req;
  logic [15:0]          wav_out_data;
  logic                 wav_out_valid;
  logic                 playing;
  logic [FIFO_AW:0]     fifo_level;
  logic [CNT_W-1:0]     underflow_cnt;
  logic [CNT_W-1:0]     overflow_cnt;
  logic [CNT_W-1:0]     odd_len_cnt;
`ifdef UDP_AUDIO_SEQ_CHECK_EN
  logic [CNT_W-1:0]     seq_gap_cnt;
`endif

  modport master (
    output udp_rec_data_valid, udp_rec_rdata, udp_rec_data_length, sample_req,
    input  wav_out_data, wav_out_valid, playing, fifo_level, underflow_cnt, overflow_cnt,
`ifdef UDP_AUDIO_SEQ_CHECK_EN
           seq_gap_cnt,
`endif
           odd_len_cnt
  );

  modport slave (
    input  udp_rec_data_valid, udp_rec_rdata, udp_rec_data_length, sample_req,
    output wav_out_data, wav_out_valid, playing, fifo_level, underflow_cnt, overflow_cnt,
`ifdef UDP_AUDIO_SEQ_CHECK_EN
           seq_gap_cnt,
`endif
           odd_len_cnt
  );
endinterface

// File: rtl/udp_audio_depacketizer.sv
// Reassembles 16-bit PCM samples from a UDP payload byte stream into a FIFO and plays one per
// DAC strobe with prefill/underflow handling. Optional macro: UDP_AUDIO_SEQ_CHECK_EN.
module udp_audio_depacketizer #(
  parameter int unsigned FIFO_AW = 8,
  parameter int unsigned PREFILL = 128,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      clk_in1,
  input  logic                      rst_n,
  udp_audio_depacketizer_if.slave   bus
);
  localparam int unsigned LVL_W  = FIFO_AW + 1;
  localparam int unsigned DEPTH  = 1 << FIFO_AW;
  localparam int unsigned BCNT_W = 16;
  localparam logic [LVL_W-1:0] PREFILL_LVL = LVL_W'(PREFILL);

`ifdef UDP_AUDIO_SEQ_CHECK_EN
  typedef enum logic [2:0] {RX_IDLE, RX_SEQ_HI, RX_SEQ_LO, RX_HI, RX_LO} rx_state_e;
`else
  typedef enum logic [1:0] {RX_IDLE, RX_HI, RX_LO} rx_state_e;
`endif
  typedef enum logic {WAIT_FILL, PLAY} pb_state_e;

  rx_state_e          rx_state_q, rx_state_d;
  pb_state_e          pb_state_q, pb_state_d;
  logic [7:0]         hi_q, hi_d;
  logic [15:0]        len_q, len_d;
  logic [BCNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [LVL_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
  logic [15:0]        wav_data_q, wav_data_d;
  logic               wav_valid_q, wav_valid_d;
  logic               playing_q, playing_d;
  logic [CNT_W-1:0]   underflow_q, underflow_d, overflow_q, overflow_d, odd_q, odd_d;
`ifdef UDP_AUDIO_SEQ_CHECK_EN
  logic [7:0]         seq_hi_q, seq_hi_d;
  logic [15:0]        last_seq_q, last_seq_d, seq_c;
  logic               seq_seen_q, seq_seen_d;
  logic [CNT_W-1:0]   seq_gap_q, seq_gap_d;
`endif

  logic [15:0]        mem_q [DEPTH];
  logic [15:0]        sample_c;
  logic               push_req_c, push_c, pop_c, full_c, empty_c, in_range_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Next-state and output logic for both the receive and playback sides
  always_comb begin
    rx_state_d  = rx_state_q;
    pb_state_d  = pb_state_q;
    hi_d        = hi_q;
    len_d       = len_q;
    byte_cnt_d  = byte_cnt_q;
    wav_data_d  = '0;
    wav_valid_d = 1'b0;
    underflow_d = underflow_q;
    overflow_d  = overflow_q;
    odd_d       = odd_q;
    push_req_c  = 1'b0;
    push_c      = 1'b0;
    pop_c       = 1'b0;
    sample_c    = {hi_q, bus.udp_rec_rdata};
    in_range_c  = (len_q == '0) || (byte_cnt_q < len_q);
    full_c      = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                  (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    empty_c     = (wr_ptr_q == rd_ptr_q);
`ifdef UDP_AUDIO_SEQ_CHECK_EN
    seq_hi_d    = seq_hi_q;
    last_seq_d  = last_seq_q;
    seq_seen_d  = seq_seen_q;
    seq_gap_d   = seq_gap_q;
    seq_c       = {seq_hi_q, bus.udp_rec_rdata};
`endif

    if (!bus.udp_rec_data_valid) begin
      // End of run: a dangling high byte makes the packet odd
      if (rx_state_q == RX_LO) odd_d = sat_inc(odd_q);
      rx_state_d = RX_IDLE;
    end else if (rx_state_q == RX_IDLE) begin
      len_d      = bus.udp_rec_data_length;
      byte_cnt_d = BCNT_W'(1);
`ifdef UDP_AUDIO_SEQ_CHECK_EN
      seq_hi_d   = bus.udp_rec_rdata;
      rx_state_d = RX_SEQ_LO;
`else
      hi_d       = bus.udp_rec_rdata;
      rx_state_d = RX_LO;
`endif
    end else if (in_range_c) begin
      byte_cnt_d = (byte_cnt_q == '1) ? byte_cnt_q : byte_cnt_q + BCNT_W'(1);
      case (rx_state_q)
        RX_HI: begin
          hi_d       = bus.udp_rec_rdata;
          rx_state_d = RX_LO;
        end
        RX_LO: begin
          push_req_c = 1'b1;
          rx_state_d = RX_HI;
        end
`ifdef UDP_AUDIO_SEQ_CHECK_EN
        RX_SEQ_HI: begin
          seq_hi_d   = bus.udp_rec_rdata;
          rx_state_d = RX_SEQ_LO;
        end
        RX_SEQ_LO: begin
          if (seq_seen_q && (seq_c != last_seq_q + 16'(1))) seq_gap_d = sat_inc(seq_gap_q);
          last_seq_d = seq_c;
          seq_seen_d = 1'b1;
          rx_state_d = RX_HI;
        end
`endif
        default: ;
      endcase
    end

    if (push_req_c) begin
      if (full_c) overflow_d = sat_inc(overflow_q);
      else        push_c     = 1'b1;
    end

    case (pb_state_q)
      WAIT_FILL: begin
        if (bus.sample_req) wav_valid_d = 1'b1;
        if (level_q >= PREFILL_LVL) pb_state_d = PLAY;
      end
      PLAY: begin
        if (bus.sample_req) begin
          wav_valid_d = 1'b1;
          if (!empty_c) begin
            pop_c      = 1'b1;
            wav_data_d = mem_q[rd_ptr_q[FIFO_AW-1:0]];
          end else begin
            underflow_d = sat_inc(underflow_q);
            pb_state_d  = WAIT_FILL;
          end
        end
      end
      default: pb_state_d = WAIT_FILL;
    endcase

    wr_ptr_d  = push_c ? wr_ptr_q + LVL_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop_c  ? rd_ptr_q + LVL_W'(1) : rd_ptr_q;
    level_d   = wr_ptr_d - rd_ptr_d;
    playing_d = (pb_state_d == PLAY);
  end

  always_ff @(posedge clk_in1) begin
    if (!rst_n) begin
      rx_state_q  <= RX_IDLE;
      pb_state_q  <= WAIT_FILL;
      hi_q        <= '0;
      len_q       <= '0;
      byte_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      wav_data_q  <= '0;
      wav_valid_q <= 1'b0;
      playing_q   <= 1'b0;
      underflow_q <= '0;
      overflow_q  <= '0;
      odd_q       <= '0;
`ifdef UDP_AUDIO_SEQ_CHECK_EN
      seq_hi_q    <= '0;
      last_seq_q  <= '0;
      seq_seen_q  <= 1'b0;
      seq_gap_q   <= '0;
`endif
    end else begin
      rx_state_q  <= rx_state_d;
      pb_state_q  <= pb_state_d;
      hi_q        <= hi_d;
      len_q       <= len_d;
      byte_cnt_q  <= byte_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      wav_data_q  <= wav_data_d;
      wav_valid_q <= wav_valid_d;
      playing_q   <= playing_d;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
      odd_q       <= odd_d;
`ifdef UDP_AUDIO_SEQ_CHECK_EN
      seq_hi_q    <= seq_hi_d;
      last_seq_q  <= last_seq_d;
      seq_seen_q  <= seq_seen_d;
      seq_gap_q   <= seq_gap_d;
`endif
    end
  end

  // Sample storage; contents are meaningless once pointers reset
  always_ff @(posedge clk_in1) begin
    if (push_c) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= sample_c;
  end

  assign bus.wav_out_data  = wav_data_q;
  assign bus.wav_out_valid = wav_valid_q;
  assign bus.playing       = playing_q;
  assign bus.fifo_level    = level_q;
  assign bus.underflow_cnt = underflow_q;
  assign bus.overflow_cnt  = overflow_q;
  assign bus.odd_len_cnt   = odd_q;
`ifdef UDP_AUDIO_SEQ_CHECK_EN
  assign bus.seq_gap_cnt   = seq_gap_q;
`endif

endmodule

// File: tb/tb_udp_audio_depacketizer.sv
// Directed bench for udp_audio_depacketizer: packet table plus prefill, underflow, overflow,
// simultaneous push/pop and mid-packet reset sequences.
module tb_udp_audio_depacketizer;
  logic clk_in1 = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_in1 = ~clk_in1;

  udp_audio_depacketizer_if #(.FIFO_AW(8), .CNT_W(16)) bus ();

  udp_audio_depacketizer #(.FIFO_AW(8), .PREFILL(128), .CNT_W(16)) dut (
    .clk_in1 (clk_in1),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [3:0]  nbytes;
    logic [47:0] bytes;     // send order: bytes[47:40] first
    logic [15:0] len;
    logic [8:0]  exp_level; // cumulative FIFO level after the packet
    logic [7:0]  exp_odd;   // cumulative odd_len_cnt after the packet
    logic [1:0]  nsmp;
    logic [47:0] smp;       // samples written, first in smp[47:32]
  } vec_t;

  vec_t        vecs [6];
  logic [7:0]  pkt_q [$];
  logic [15:0] exp_q [$];
  logic [15:0] seq_nxt = 16'd0;
  logic        cap_v;
  logic [15:0] cap_d;
  int          checks = 0;
  int          errors = 0;

  task automatic tick();
    @(posedge clk_in1);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] smp(input int k);
    return 16'((k * 40503) ^ 32'h5A5A);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Sends pkt_q as one contiguous run; optionally strobes sample_req on the last byte
  task automatic send_packet(input logic [15:0] len, input bit req_last);
    logic [15:0] l;
    l = len;
`ifdef UDP_AUDIO_SEQ_CHECK_EN
    if (l != 16'd0) l = l + 16'd2;
    pkt_q.push_front(seq_nxt[7:0]);
    pkt_q.push_front(seq_nxt[15:8]);
    seq_nxt = seq_nxt + 16'd1;
`endif
    for (int i = 0; i < pkt_q.size(); i++) begin
      bus.udp_rec_data_valid  = 1'b1;
      bus.udp_rec_rdata       = pkt_q[i];
      bus.udp_rec_data_length = l;
      bus.sample_req          = req_last && (i == pkt_q.size() - 1);
      tick();
    end
    cap_v = bus.wav_out_valid;
    cap_d = bus.wav_out_data;
    bus.udp_rec_data_valid = 1'b0;
    bus.sample_req         = 1'b0;
    tick();
    tick();
    pkt_q.delete();
  endtask

  task automatic fill(input int n, input int base);
    logic [15:0] s;
    for (int k = 0; k < n; k++) begin
      s = smp(base + k);
      pkt_q.push_back(s[15:8]);
      pkt_q.push_back(s[7:0]);
    end
    send_packet(16'd0, 1'b0);
  endtask

  task automatic pop_check(input string name, input logic [15:0] exp);
    bus.sample_req = 1'b1;
    tick();
    bus.sample_req = 1'b0;
    check({name, " valid"}, 32'(bus.wav_out_valid), 32'd1);
    check({name, " data"}, 32'(bus.wav_out_data), 32'(exp));
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [47:0] bb;
    logic [15:0] w;
    vecs[0] = '{4'd4, 48'h1234ABCD0000, 16'd4, 9'd2,  8'd0, 2'd2, 48'h1234ABCD0000};
    vecs[1] = '{4'd5, 48'h010203040500, 16'd0, 9'd4,  8'd1, 2'd2, 48'h010203040000};
    vecs[2] = '{4'd2, 48'h0A0B00000000, 16'd2, 9'd5,  8'd1, 2'd1, 48'h0A0B00000000};
    vecs[3] = '{4'd6, 48'h112233445566, 16'd4, 9'd7,  8'd1, 2'd2, 48'h112233440000};
    vecs[4] = '{4'd3, 48'h778899000000, 16'd3, 9'd8,  8'd2, 2'd1, 48'h778800000000};
    vecs[5] = '{4'd5, 48'hC1C2C3C4C500, 16'd4, 9'd10, 8'd2, 2'd2, 48'hC1C2C3C40000};

    bus.udp_rec_data_valid  = 1'b0;
    bus.udp_rec_rdata       = 8'h00;
    bus.udp_rec_data_length = 16'd0;
    bus.sample_req          = 1'b0;
    do_reset();

    check("reset level",     32'(bus.fifo_level),    32'd0);
    check("reset valid",     32'(bus.wav_out_valid), 32'd0);
    check("reset data",      32'(bus.wav_out_data),  32'd0);
    check("reset playing",   32'(bus.playing),       32'd0);
    check("reset underflow", 32'(bus.underflow_cnt), 32'd0);
    check("reset overflow",  32'(bus.overflow_cnt),  32'd0);
    check("reset odd",       32'(bus.odd_len_cnt),   32'd0);

    // Packet table: reassembly, length limit and odd-length handling
    for (int v = 0; v < 6; v++) begin
      bb = vecs[v].bytes;
      for (int i = 0; i < int'(vecs[v].nbytes); i++) pkt_q.push_back(bb[47 - 8*i -: 8]);
      send_packet(vecs[v].len, 1'b0);
      bb = vecs[v].smp;
      for (int i = 0; i < int'(vecs[v].nsmp); i++) exp_q.push_back(bb[47 - 16*i -: 16]);
      check($sformatf("vec%0d level", v), 32'(bus.fifo_level), 32'(vecs[v].exp_level));
      check($sformatf("vec%0d odd", v),   32'(bus.odd_len_cnt), 32'(vecs[v].exp_odd));
    end
    fill(130, 0);
    check("T1 level",   32'(bus.fifo_level), 32'd140);
    check("T1 playing", 32'(bus.playing),    32'd1);
    for (int i = 0; i < 10; i++) pop_check($sformatf("T1 pop%0d", i), exp_q[i]);
    exp_q.delete();
`ifdef UDP_AUDIO_SEQ_CHECK_EN
    check("T1 seq gap", 32'(bus.seq_gap_cnt), 32'd0);
`endif

    // Prefill then underflow
    do_reset();
    fill(127, 0);
    check("T2 level",   32'(bus.fifo_level), 32'd127);
    for (int i = 0; i < 3; i++) pop_check($sformatf("T2 mute%0d", i), 16'h0000);
    check("T2 underflow", 32'(bus.underflow_cnt), 32'd0);
    check("T2 playing",   32'(bus.playing),       32'd0);
    fill(1, 127);
    check("T2 playing after fill", 32'(bus.playing), 32'd1);
    for (int i = 0; i < 128; i++) pop_check($sformatf("T3 drain%0d", i), smp(i));
    check("T3 level empty", 32'(bus.fifo_level), 32'd0);
    pop_check("T3 underflow out", 16'h0000);
    check("T3 underflow", 32'(bus.underflow_cnt), 32'd1);
    check("T3 playing",   32'(bus.playing),       32'd0);

    // Overflow, then a push coinciding with a pop
    do_reset();
    fill(260, 1000);
    check("T5 level",    32'(bus.fifo_level),   32'd256);
    check("T5 overflow", 32'(bus.overflow_cnt), 32'd4);
    check("T5 playing",  32'(bus.playing),      32'd1);
    pop_check("T5 pop0", smp(1000));
    pkt_q.push_back(8'hBE);
    pkt_q.push_back(8'hEF);
    send_packet(16'd0, 1'b1);
    check("T5 pushpop valid", 32'(cap_v), 32'd1);
    check("T5 pushpop data",  32'(cap_d), 32'(smp(1001)));
    check("T5 pushpop level", 32'(bus.fifo_level), 32'd255);
    for (int i = 2; i < 256; i++) pop_check($sformatf("T5 pop%0d", i), smp(1000 + i));
    pop_check("T5 pop tail", 16'hBEEF);
    check("T5 level empty", 32'(bus.fifo_level), 32'd0);

    // Reset in the middle of a packet
    do_reset();
    fill(50, 2000);
    pkt_q.push_back(8'h01);
    pkt_q.push_back(8'h02);
    pkt_q.push_back(8'h03);
    send_packet(16'd0, 1'b0);
    check("T6 pre level", 32'(bus.fifo_level),  32'd51);
    check("T6 pre odd",   32'(bus.odd_len_cnt), 32'd1);
    bus.udp_rec_data_valid = 1'b1;
    bus.udp_rec_rdata      = 8'h55;
    tick();
    bus.udp_rec_rdata = 8'h66;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.udp_rec_data_valid = 1'b0;
    tick();
    check("T6 level",     32'(bus.fifo_level),    32'd0);
    check("T6 odd",       32'(bus.odd_len_cnt),   32'd0);
    check("T6 overflow",  32'(bus.overflow_cnt),  32'd0);
    check("T6 underflow", 32'(bus.underflow_cnt), 32'd0);
    check("T6 playing",   32'(bus.playing),       32'd0);
    pkt_q.push_back(8'h00);
    pkt_q.push_back(8'h01);
    send_packet(16'd2, 1'b0);
    check("T6 post level", 32'(bus.fifo_level), 32'd1);
    fill(127, 3000);
    check("T6 playing after fill", 32'(bus.playing), 32'd1);
    pop_check("T6 first", 16'h0001);

`ifdef UDP_AUDIO_SEQ_CHECK_EN
    do_reset();
    check("seq gap reset", 32'(bus.seq_gap_cnt), 32'd0);
    seq_nxt = 16'd5;
    pkt_q.push_back(8'hAA);
    pkt_q.push_back(8'hBB);
    send_packet(16'd2, 1'b0);
    check("seq first", 32'(bus.seq_gap_cnt), 32'd0);
    seq_nxt = 16'd7;
    pkt_q.push_back(8'hCC);
    pkt_q.push_back(8'hDD);
    send_packet(16'd2, 1'b0);
    check("seq gap", 32'(bus.seq_gap_cnt), 32'd1);
    check("seq audio kept", 32'(bus.fifo_level), 32'd2);
`endif

    w = 16'd0;
    if (w != 16'd0) $display("unexpected");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
